// File: rtl/multi_key_req_gen.sv
// Multi-channel key requester: NUM_CH stride counters with limit/wrap/stop behaviour,
// arbitrated round-robin onto a single registered req/ack port.
module multi_key_req_gen #(
    parameter int KEY_W  = 4,
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [KEY_W-1:0]  stride,
    input  logic [KEY_W-1:0]  limit,
    input  logic              wrap_mode,
    input  logic              clear,
    output logic              req,
    output logic [KEY_W-1:0]  req_key,
    output logic [CH_W-1:0]   req_ch,
    input  logic              ack,
    output logic [NUM_CH-1:0] done
);

    // Valid/ready: req/req_key/req_ch are registered and held until an edge
    // with req & ack (a transfer); ack with req low has no effect.
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

    logic [KEY_W-1:0]  cnt_q [NUM_CH];
    logic [KEY_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] done_d;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   ptr_d;
    logic              req_d;
    logic [KEY_W-1:0]  key_d;
    logic [CH_W-1:0]   ch_d;
    logic              xfer;
    logic [NUM_CH-1:0] elig;
    logic              found;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   cand;
    int                idx;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done;
        ptr_d  = ptr_q;
        req_d  = req;
        key_d  = req_key;
        ch_d   = req_ch;
        xfer   = req & ack;
        elig   = '0;
        found  = 1'b0;
        sel    = '0;
        cand   = '0;
        idx    = 0;

        if (clear) begin
            // clear wins over a simultaneous ack: nothing is transferred
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = '0;
            end
            done_d = '0;
            ptr_d  = PTR_RST;
            req_d  = 1'b0;
            key_d  = '0;
            ch_d   = '0;
        end else begin
            if (xfer) begin
                if (req_key >= limit) begin
                    if (wrap_mode) begin
                        cnt_d[req_ch] = '0;
                    end else begin
                        cnt_d[req_ch]  = req_key;
                        done_d[req_ch] = 1'b1;
                    end
                end else begin
                    cnt_d[req_ch] = req_key + stride;
                end
                ptr_d = req_ch;
            end

            // Issue from post-update state so back-to-back transfers have no bubble
            if (!req || xfer) begin
                elig = ch_en & ~done_d;
                for (int i = 1; i <= NUM_CH; i++) begin
                    idx  = (int'(ptr_d) + i) % NUM_CH;
                    cand = CH_W'(idx);
                    if (!found && elig[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                req_d = found;
                if (found) begin
                    key_d = cnt_d[sel];
                    ch_d  = sel;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            done    <= '0;
            ptr_q   <= PTR_RST;
            req     <= 1'b0;
            req_key <= '0;
            req_ch  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            done    <= done_d;
            ptr_q   <= ptr_d;
            req     <= req_d;
            req_key <= key_d;
            req_ch  <= ch_d;
        end
    end

    // A pending request must hold its payload until accepted or cleared
    held_req_stable: assert property (@(posedge clk) disable iff (rst)
        (req && !ack && !clear) |=> (req && $stable(req_key) && $stable(req_ch)));

    ch_in_range: assert property (@(posedge clk) disable iff (rst)
        req |-> (int'(req_ch) < NUM_CH));

endmodule

// File: tb/tb_multi_key_req_gen.sv
// Directed bench for multi_key_req_gen: a single-channel instance and a two-channel
// instance, table-driven round-robin/stop vectors plus hand-written corner sequences.
module tb_multi_key_req_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ch_en;
    logic       ch_en1;
    logic [3:0] stride;
    logic [3:0] limit;
    logic       wrap_mode;
    logic       clear;
    logic       ack;

    logic       req;
    logic [3:0] req_key;
    logic       req_ch;
    logic [1:0] done;

    logic       req1;
    logic [3:0] req_key1;
    logic       req_ch1;
    logic       done1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] en;
        logic [3:0] stride;
        logic [3:0] limit;
        logic       wrap;
        logic       clr;
        logic       ack;
        logic       exp_req;
        logic [3:0] exp_key;
        logic       exp_ch;
        logic [1:0] exp_done;
    } vec_t;

    vec_t tbl[$];

    multi_key_req_gen #(.KEY_W(4), .NUM_CH(2)) u_dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .stride(stride), .limit(limit),
        .wrap_mode(wrap_mode), .clear(clear), .req(req), .req_key(req_key),
        .req_ch(req_ch), .ack(ack), .done(done)
    );

    multi_key_req_gen #(.KEY_W(4), .NUM_CH(1)) u_dut1 (
        .clk(clk), .rst(rst), .ch_en(ch_en1), .stride(stride), .limit(limit),
        .wrap_mode(wrap_mode), .clear(clear), .req(req1), .req_key(req_key1),
        .req_ch(req_ch1), .ack(ack), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] en, input logic [3:0] s, input logic [3:0] l,
                                input logic w, input logic c, input logic a, input logic er,
                                input logic [3:0] ek, input logic ec, input logic [1:0] ed);
        vec_t v;
        v.en = en; v.stride = s; v.limit = l; v.wrap = w; v.clr = c; v.ack = a;
        v.exp_req = er; v.exp_key = ek; v.exp_ch = ec; v.exp_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // key/ch are only meaningful while a request is pending
    task automatic chk2(input string tag, input logic er, input logic [3:0] ek,
                        input logic ec, input logic [1:0] ed);
        chk({tag, ".req"}, 32'(req), 32'(er));
        if (er) begin
            chk({tag, ".key"}, 32'(req_key), 32'(ek));
            chk({tag, ".ch"}, 32'(req_ch), 32'(ec));
        end
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic drive(input logic [1:0] en, input logic [3:0] s, input logic [3:0] l,
                         input logic w, input logic c, input logic a);
        ch_en     = en;
        stride    = s;
        limit     = l;
        wrap_mode = w;
        clear     = c;
        ack       = a;
    endtask

    initial begin
        logic [3:0] rr_keys [7];
        rr_keys = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd0};

        // round-robin, stride 3, wrap at 15
        for (int n = 1; n <= 14; n++) begin
            tbl.push_back(mk(2'b11, 4'd3, 4'd15, 1'b1, 1'b0, 1'b1,
                             1'b1, rr_keys[(n - 1) / 2], 1'((n - 1) % 2), 2'b00));
        end
        tbl.push_back(mk(2'b11, 4'd3, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00));
        // stop mode on ch0: limit 5, stride 2
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 2'b00));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 2'b00));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 2'b00));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b01));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 2'b01));
        tbl.push_back(mk(2'b01, 4'd2, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 2'b00));

        rst    = 1'b1;
        ch_en1 = 1'b0;
        drive(2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk2("reset", 1'b0, 4'd0, 1'b0, 2'b00);
        chk("reset.key", 32'(req_key), 32'd0);
        chk("reset.ch", 32'(req_ch), 32'd0);
        chk("reset1.req", 32'(req1), 32'd0);
        rst = 1'b0;

        // single channel, stride 1, wrap at 15, ack always high
        ch_en1 = 1'b1;
        drive(2'b00, 4'd1, 4'd15, 1'b1, 1'b0, 1'b1);
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            chk($sformatf("one_ch%0d.req", n), 32'(req1), 32'd1);
            chk($sformatf("one_ch%0d.key", n), 32'(req_key1), 32'((n - 1) % 16));
            chk($sformatf("one_ch%0d.ch", n), 32'(req_ch1), 32'd0);
        end
        ch_en1 = 1'b0;
        drive(2'b00, 4'd1, 4'd15, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("one_ch_clear.req", 32'(req1), 32'd0);
        chk("one_ch_clear.done", 32'(done1), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].stride, tbl[i].limit, tbl[i].wrap, tbl[i].clr, tbl[i].ack);
            @(negedge clk);
            chk2($sformatf("tbl%0d", i), tbl[i].exp_req, tbl[i].exp_key, tbl[i].exp_ch,
                 tbl[i].exp_done);
        end

        // stall with key 7 pending on ch1; dropping ch_en must not retract it
        drive(2'b10, 4'd7, 4'd15, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk2("stall_first", 1'b1, 4'd0, 1'b1, 2'b00);
        @(negedge clk);
        chk2("stall_k7", 1'b1, 4'd7, 1'b1, 2'b00);
        drive(2'b10, 4'd7, 4'd15, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) ch_en = 2'b00;
            @(negedge clk);
            chk2($sformatf("stall_hold%0d", i), 1'b1, 4'd7, 1'b1, 2'b00);
        end
        drive(2'b00, 4'd7, 4'd15, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk2($sformatf("stall_idle%0d", i), 1'b0, 4'd0, 1'b0, 2'b00);
        end
        drive(2'b10, 4'd7, 4'd15, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk2("stall_adv", 1'b1, 4'd14, 1'b1, 2'b00);

        // clear coinciding with ack on key 4
        drive(2'b00, 4'd4, 4'd15, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk2("clr_pre", 1'b0, 4'd0, 1'b0, 2'b00);
        drive(2'b11, 4'd4, 4'd15, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk2("clr_s0", 1'b1, 4'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk2("clr_s1", 1'b1, 4'd0, 1'b1, 2'b00);
        @(negedge clk);
        chk2("clr_s2", 1'b1, 4'd4, 1'b0, 2'b00);
        drive(2'b11, 4'd4, 4'd15, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk2("clr_hit", 1'b0, 4'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk2("clr_hold", 1'b0, 4'd0, 1'b0, 2'b00);
        drive(2'b11, 4'd4, 4'd15, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk2("clr_after0", 1'b1, 4'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk2("clr_after1", 1'b1, 4'd0, 1'b1, 2'b00);

        // limit 0 stop mode sets done0, then async reset mid-cycle
        drive(2'b11, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk2("rst_pre", 1'b0, 4'd0, 1'b0, 2'b00);
        drive(2'b11, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk2("rst_s0", 1'b1, 4'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk2("rst_s1", 1'b1, 4'd0, 1'b1, 2'b01);
        #2 rst = 1'b1;
        #1;
        chk2("rst_async", 1'b0, 4'd0, 1'b0, 2'b00);
        chk("rst_async.key", 32'(req_key), 32'd0);
        #1 rst = 1'b0;
        drive(2'b11, 4'd1, 4'd15, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk2("rst_restart0", 1'b1, 4'd0, 1'b0, 2'b00);
        @(negedge clk);
        chk2("rst_restart1", 1'b1, 4'd0, 1'b1, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
